// File: rtl/lsu_mem_master.sv
// Load/store initiator to a byte-addressed word-port RAM: B/H/W loads with extension, sub-word stores by read-modify-write.
// Optional `MISALIGN_TRAP_EN rejects misaligned halfword/word accesses through the error path.
module lsu_mem_master #(
  parameter int WIDTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             resp_valid_o,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  typedef enum logic [2:0] {IDLE, LD_RD, ST_RD, ST_WR, RESP} state_t;

  state_t           state;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] wdata_q;
  logic             f3_legal;
  logic             misalign;
  logic [WIDTH-1:0] ld_ext;
  logic [WIDTH-1:0] merged;

  always_comb begin
    if (req_we_i)
      f3_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010);
    else
      f3_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010) ||
                 (req_funct3_i == 3'b100) || (req_funct3_i == 3'b101);
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
               ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end
`else
  always_comb begin
    misalign = 1'b0;
  end
`endif

  always_comb begin
    ld_ext = mem_rd_i;
    case (f3_q)
      3'b000:  ld_ext = {{(WIDTH-DATA_W){mem_rd_i[DATA_W-1]}}, mem_rd_i[DATA_W-1:0]};
      3'b001:  ld_ext = {{(WIDTH-2*DATA_W){mem_rd_i[2*DATA_W-1]}}, mem_rd_i[2*DATA_W-1:0]};
      3'b100:  ld_ext = {{(WIDTH-DATA_W){1'b0}}, mem_rd_i[DATA_W-1:0]};
      3'b101:  ld_ext = {{(WIDTH-2*DATA_W){1'b0}}, mem_rd_i[2*DATA_W-1:0]};
      default: ld_ext = mem_rd_i;
    endcase
  end

  always_comb begin
    merged = mem_rd_i;
    case (f3_q[1:0])
      2'b00:   merged[DATA_W-1:0]   = wdata_q[DATA_W-1:0];
      2'b01:   merged[2*DATA_W-1:0] = wdata_q[2*DATA_W-1:0];
      default: merged               = wdata_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      mem_we_o     <= 1'b0;
      mem_a_o      <= '0;
      mem_wd_o     <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      mem_we_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            f3_q         <= req_funct3_i;
            wdata_q      <= req_wdata_i;
            mem_a_o      <= req_addr_i;
            resp_rdata_o <= '0;
            req_ready_o  <= 1'b0;
            if (!f3_legal || misalign) begin
              resp_err_o   <= 1'b1;
              resp_valid_o <= 1'b1;
              state        <= RESP;
            end else if (!req_we_i) begin
              state <= LD_RD;
            end else if (req_funct3_i[1:0] == 2'b10) begin
              // full-word store skips the read and writes next cycle
              mem_wd_o <= req_wdata_i;
              mem_we_o <= 1'b1;
              state    <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        LD_RD: begin
          resp_rdata_o <= ld_ext;
          resp_valid_o <= 1'b1;
          state        <= RESP;
        end
        ST_RD: begin
          mem_wd_o <= merged;
          mem_we_o <= 1'b1;
          state    <= ST_WR;
        end
        ST_WR: begin
          resp_valid_o <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          resp_err_o  <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-array RAM, transaction-level model, per-cycle compare against it.
module tb_lsu_mem_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic [31:0] mem_a_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  lsu_mem_master #(.WIDTH(32), .DATA_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  ram [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;
  logic [11:0] ma;

  assign ma = mem_a_o[11:0];
  assign mem_rd_i = {ram[12'(ma + 12'd3)], ram[12'(ma + 12'd2)], ram[12'(ma + 12'd1)], ram[ma]};

  always @(posedge clk_i) begin
    if (mem_we_o) begin
      for (int unsigned k = 0; k < 4; k++) ram[12'(ma + 12'(k))] <= mem_wd_o[8*k +: 8];
    end else if (pl_we) begin
      for (int unsigned k = 0; k < 4; k++) ram[12'(pl_a + 12'(k))] <= pl_d[8*k +: 8];
    end
  end

  function automatic logic [31:0] rd_word(input logic [11:0] a);
    return {ram[12'(a + 12'd3)], ram[12'(a + 12'd2)], ram[12'(a + 12'd1)], ram[a]};
  endfunction

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Transaction model: outcome derived from the access size and funct3 rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rdat, output logic [31:0] wword);
    logic [31:0] rd;
    logic [31:0] mask;
    int          sz;
    bit          legal;
    rd    = rd_word(a[11:0]);
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef MISALIGN_TRAP_EN
    if (legal && (a % sz) != 0) legal = 0;
`endif
    err   = !legal;
    rdat  = '0;
    wword = '0;
    mask  = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    if (!legal) lat = 1;
    else if (!we) begin
      lat = 2;
      case (f3)
        3'd0:    rdat = 32'($signed(rd[7:0]));
        3'd1:    rdat = 32'($signed(rd[15:0]));
        3'd4:    rdat = rd & 32'hFF;
        3'd5:    rdat = rd & 32'hFFFF;
        default: rdat = rd;
      endcase
    end else begin
      lat   = (sz == 4) ? 2 : 3;
      wword = (rd & ~mask) | (wd & mask);
    end
  endtask

  bit          mon_en = 0;
  int          e_acc = -10, e_resp = -10, e_we = -10;
  logic [31:0] e_addr = '0, e_rdata = '0, e_wd = '0;
  logic        e_err = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("ready", {31'd0, req_ready_o}, {31'd0, !(cyc >= e_acc && cyc <= e_resp)});
      chk("resp_valid", {31'd0, resp_valid_o}, {31'd0, cyc == e_resp});
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, cyc == e_we});
      if (cyc >= e_acc && cyc <= e_resp) chk("mem_a", mem_a_o, e_addr);
      if (cyc == e_resp) begin
        chk("rdata", resp_rdata_o, e_rdata);
        chk("err", {31'd0, resp_err_o}, {31'd0, e_err});
        last_rdata = resp_rdata_o;
        last_err   = resp_err_o;
      end
      if (cyc == e_we) chk("mem_wd", mem_wd_o, e_wd);
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_i);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk_i);
    #1 pl_we = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rdat, output logic er);
    int          lat;
    logic        m_err;
    logic [31:0] m_rd, m_wd;
    @(negedge clk_i);
    model(we, f3, a, wd, lat, m_err, m_rd, m_wd);
    e_addr  = a;
    e_rdata = m_rd;
    e_err   = m_err;
    e_wd    = m_wd;
    e_we    = (we && !m_err) ? cyc + lat - 1 : -10;
    e_acc   = cyc + 1;
    e_resp  = cyc + lat;
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
    @(posedge clk_i);
    if (hold) begin
      #1;
      req_we_i = ~we; req_funct3_i = 3'b010; req_addr_i = a ^ 32'h40; req_wdata_i = ~wd;
      repeat (lat - 1) @(posedge clk_i);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int i = 0; i < 10 && cyc <= e_resp; i++) @(negedge clk_i);
    if (cyc <= e_resp) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no completion by cycle %0d, expected at %0d", cyc, e_resp);
    end
    rdat = last_rdata;
    er   = last_err;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0; req_addr_i = '0; req_wdata_i = '0;
    #3;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_err", {31'd0, resp_err_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_a", mem_a_o, 32'd0);
    chk("rst_mem_wd", mem_wd_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;

    preload(12'h100, 32'h1234_5678);
    preload(12'h104, 32'h0000_0000);
    preload(12'h200, 32'h0000_F080);
    preload(12'h300, 32'hAABB_CCDD);
    preload(12'h400, 32'h0102_0304);
    @(negedge clk_i) mon_en = 1;

    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, rd, er);
    chk("lw_100", rd, 32'h1234_5678);
    chk("lw_100_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 3'b000, 32'h200, 32'h0, 0, rd, er);
    chk("lb_200", rd, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h200, 32'h0, 0, rd, er);
    chk("lbu_200", rd, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h200, 32'h0, 0, rd, er);
    chk("lh_200", rd, 32'hFFFF_F080);
    do_req(1'b0, 3'b101, 32'h200, 32'h0, 1, rd, er);
    chk("lhu_200", rd, 32'h0000_F080);

    do_req(1'b1, 3'b000, 32'h300, 32'h0000_0011, 0, rd, er);
    @(negedge clk_i);
    chk("sb_300_ram", rd_word(12'h300), 32'hAABB_CC11);
    chk("sb_300_rdata", rd, 32'd0);

    do_req(1'b1, 3'b001, 32'h301, 32'h0000_BEEF, 0, rd, er);
    @(negedge clk_i);
`ifdef MISALIGN_TRAP_EN
    chk("sh_301_err", {31'd0, er}, 32'd1);
    chk("sh_301_ram", rd_word(12'h300), 32'hAABB_CC11);
`else
    chk("sh_301_err", {31'd0, er}, 32'd0);
    chk("sh_301_ram", rd_word(12'h300), 32'hAABE_EF11);
`endif

    do_req(1'b0, 3'b010, 32'h101, 32'h0, 0, rd, er);
`ifdef MISALIGN_TRAP_EN
    chk("lw_101", rd, 32'd0);
`else
    chk("lw_101", rd, 32'h0012_3456);
`endif

    do_req(1'b0, 3'b011, 32'h100, 32'h0, 1, rd, er);
    chk("ld_f3_011_err", {31'd0, er}, 32'd1);
    chk("ld_f3_011_rdata", rd, 32'd0);
    do_req(1'b0, 3'b110, 32'h100, 32'h0, 0, rd, er);
    chk("ld_f3_110_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b011, 32'h300, 32'h5555_5555, 1, rd, er);
    chk("st_f3_011_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b010, 32'h500, 32'hCAFE_F00D, 1, rd, er);
    @(negedge clk_i);
    chk("sw_500_ram", rd_word(12'h500), 32'hCAFE_F00D);

    // reset while ST_WR is driving the write enable
    mon_en = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
    req_addr_i = 32'h400; req_wdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    chk("stwr_we_before_rst", {31'd0, mem_we_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_drops_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_ready_mid", {31'd0, req_ready_o}, 32'd1);
    chk("rst_no_resp", {31'd0, resp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ram_unchanged", rd_word(12'h400), 32'h0102_0304);
    mon_en = 1;
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 0, rd, er);
    chk("lw_400_after_rst", rd, 32'h0102_0304);

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
